// File: rtl/qos_pkg.sv
// qos_pkg: shared class count, index width, FSM encodings and default weight for the QoS scheduler
package qos_pkg;
  localparam int NUM_CLASSES = 4;
  localparam int IDX_W = 2;
  localparam int DEFAULT_WEIGHT = 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SERVE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;
  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_LOAD  = S_LOAD,
    ST_SERVE = S_SERVE,
    ST_WAIT  = S_WAIT
  } state_t;
endpackage

// File: rtl/qos_scheduler_if.sv
// qos_scheduler_if: FIFO status, flow control, weight config and pop outputs of the QoS scheduler
interface qos_scheduler_if #(parameter int W_BITS = 4);
  import qos_pkg::*;
  logic [NUM_CLASSES-1:0] EMPTY;
  logic                   PAUSE;
  logic                   CFG_WE;
  logic [IDX_W-1:0]       CFG_ADDR;
  logic [W_BITS-1:0]      CFG_WDATA;
  logic [NUM_CLASSES-1:0] POP;
  logic [IDX_W-1:0]       GRANT_ID;
  logic                   VALID;
  modport master (input EMPTY, PAUSE, CFG_WE, CFG_ADDR, CFG_WDATA, output POP, GRANT_ID, VALID);
  modport slave (output EMPTY, PAUSE, CFG_WE, CFG_ADDR, CFG_WDATA, input POP, GRANT_ID, VALID);
endinterface

// File: rtl/qos_rr_pick.sv
// qos_rr_pick: combinational rotating-priority picker, first eligible class from ptr upward with wrap
module qos_rr_pick
  import qos_pkg::*;
(
  input  logic [NUM_CLASSES-1:0] elig,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_CLASSES-1:0] grant,
  output logic [IDX_W-1:0]       idx,
  output logic                   found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      if (elig[ptr + IDX_W'(i)]) begin
        idx = ptr + IDX_W'(i);
        found = 1'b1;
      end
    end
    grant = found ? NUM_CLASSES'(1) << idx : '0;
  end
endmodule

// File: rtl/qos_scheduler.sv
// qos_scheduler: weighted round-robin FIFO pop scheduler; QOS_SCHED_STRICT_PRIO_EN makes class 3 strict priority
module qos_scheduler #(
  parameter int W_BITS = 4,
  parameter int DEFAULT_WEIGHT = qos_pkg::DEFAULT_WEIGHT
) (
  input logic            CLK,
  input logic            RESET,
  qos_scheduler_if.master bus
);
  import qos_pkg::*;
  state_t                 st;
  logic [W_BITS-1:0]      weight [NUM_CLASSES];
  logic [W_BITS-1:0]      credit [NUM_CLASSES];
  logic [IDX_W-1:0]       ptr, grant_id, pick_idx;
  logic [NUM_CLASSES-1:0] pop, elig, live, pick;
  logic                   valid, found;
  always_comb begin
    elig = '0;
    live = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      elig[i] = !bus.EMPTY[i] && credit[i] != '0;
      live[i] = !bus.EMPTY[i] && weight[i] != '0;
    end
  end
  qos_rr_pick u_pick (.elig(elig), .ptr(ptr), .grant(pick), .idx(pick_idx), .found(found));
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      st       <= ST_IDLE;
      ptr      <= '0;
      pop      <= '0;
      grant_id <= '0;
      valid    <= 1'b0;
      credit   <= '{default: '0};
      weight   <= '{default: W_BITS'(DEFAULT_WEIGHT)};
    end else begin
      pop   <= '0;
      valid <= |pop;
      if (bus.CFG_WE) weight[bus.CFG_ADDR] <= bus.CFG_WDATA;
      case (st)
        ST_IDLE: if (!(&bus.EMPTY)) st <= ST_LOAD;
        ST_LOAD: begin
          credit <= weight;
          st     <= |live ? ST_SERVE : ST_IDLE;
        end
        ST_SERVE: if (!bus.PAUSE) begin
`ifdef QOS_SCHED_STRICT_PRIO_EN
          // class 3 bypasses credits and leaves the WRR pointer alone
          if (!bus.EMPTY[NUM_CLASSES-1]) begin
            pop      <= NUM_CLASSES'(1) << (NUM_CLASSES - 1);
            grant_id <= IDX_W'(NUM_CLASSES - 1);
            st       <= ST_WAIT;
          end else
`endif
          if (found) begin
            pop              <= pick;
            credit[pick_idx] <= credit[pick_idx] - W_BITS'(1);
            ptr              <= pick_idx;
            grant_id         <= pick_idx;
            st               <= ST_WAIT;
          end else st <= !(&bus.EMPTY) ? ST_LOAD : ST_IDLE;
        end
        ST_WAIT: st <= ST_SERVE;
        default: st <= ST_IDLE;
      endcase
    end
  end
  assign bus.POP      = pop;
  assign bus.GRANT_ID = grant_id;
  assign bus.VALID    = valid;
endmodule
